// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave: FSM states, data width and
// SPI mode encoding {CKP,CPH}.
package spi_slave_pkg;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 3;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      MODE0 = 2'b00,
      MODE1 = 2'b01,
      MODE2 = 2'b10,
      MODE3 = 2'b11
   } spi_mode_t;

   function automatic spi_mode_t make_mode(input logic ckp, input logic cph);
      return spi_mode_t'({ckp, cph});
   endfunction

   function automatic logic mode_ckp(input spi_mode_t mode);
      return mode[1];
   endfunction

   function automatic logic mode_cph(input spi_mode_t mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus rise/fall detection
// against a one-cycle-delayed copy of the synchronized level.
module spi_sync_edge
   import spi_slave_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic init,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              prev_r;

   // Reset value is the pin's idle level so leaving reset creates no false edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_r <= {STAGES{init}};
         prev_r <= init;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], din};
         prev_r <= sync_r[STAGES-1];
      end
   end

   assign level = sync_r[STAGES-1];
   assign rise  = level & ~prev_r;
   assign fall  = ~level & prev_r;

endmodule

// File: rtl/spi_slave.sv
// SPI slave supporting all four CKP/CPH modes, oversampling SCK/CS/MOSI on CLK.
// Mode is latched at CS fall; back-to-back bytes are supported under one CS.
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CKP,
   input  logic              CPH,
   input  logic              CS,
   input  logic              SCK,
   input  logic              MOSI,
   output logic              MISO,
   input  logic [DATA_W-1:0] tx_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy
);

   localparam logic [1:0] FLUSH_CYC = 2'(SYNC_STAGES);

   logic sck_level, sck_rise, sck_fall;
   logic cs_level, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic mosi_s;

   state_t            state_r;
   spi_mode_t         mode_r;
   logic [DATA_W-1:0] tx_shift_r;
   logic [DATA_W-1:0] rx_shift_r;
   logic [DATA_W-1:0] rx_data_r;
   logic [CNT_W-1:0]  bit_cnt_r;
   logic              first_r;
   logic              reload_r;
   logic              done_r;
   logic              rx_valid_r;
   logic              busy_r;
   logic [1:0]        flush_r;
   logic              armed_r;

   logic sck_chg_s, lead_s, trail_s, sample_s, shift_s;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
      .clk   (CLK),
      .reset (RESET),
      .init  (CKP),
      .din   (SCK),
      .level (sck_level),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk   (CLK),
      .reset (RESET),
      .init  (1'b1),
      .din   (CS),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   // MOSI uses the same depth as SCK so data and clock stay aligned.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mosi_sync_r <= '0;
      end else begin
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      end
   end

   assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
   assign sck_chg_s = sck_rise | sck_fall;
   assign lead_s    = sck_chg_s & (sck_level != mode_ckp(mode_r));
   assign trail_s   = sck_chg_s & (sck_level == mode_ckp(mode_r));
   assign sample_s  = mode_cph(mode_r) ? trail_s : lead_s;
   assign shift_s   = mode_cph(mode_r) ? lead_s  : trail_s;

   // After reset the CS synchronizer is flushed and CS must be seen high before
   // a falling edge may open a frame, so a CS held low through reset is ignored.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         flush_r <= 2'd0;
         armed_r <= 1'b0;
      end else if (flush_r != FLUSH_CYC) begin
         flush_r <= flush_r + 2'd1;
      end else if (cs_level) begin
         armed_r <= 1'b1;
      end
   end

   // Frame FSM with shift registers, bit counter and registered outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r    <= IDLE;
         mode_r     <= MODE0;
         tx_shift_r <= '0;
         rx_shift_r <= '0;
         rx_data_r  <= '0;
         bit_cnt_r  <= '0;
         first_r    <= 1'b0;
         reload_r   <= 1'b0;
         done_r     <= 1'b0;
         rx_valid_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         rx_valid_r <= done_r;
         done_r     <= 1'b0;
         if (done_r) begin
            rx_data_r <= rx_shift_r;
         end
         case (state_r)
            IDLE: begin
               if (cs_fall && armed_r) begin
                  state_r    <= ACTIVE;
                  busy_r     <= 1'b1;
                  mode_r     <= make_mode(CKP, CPH);
                  tx_shift_r <= tx_data;
                  bit_cnt_r  <= '0;
                  first_r    <= CPH;
                  reload_r   <= 1'b0;
               end
            end
            ACTIVE: begin
               if (sample_s) begin
                  rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_s};
                  bit_cnt_r  <= bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     done_r   <= 1'b1;
                     reload_r <= 1'b1;
                  end
               end
               // The first CPH=1 leading edge only presents bit 7.
               if (shift_s) begin
                  if (first_r) begin
                     first_r <= 1'b0;
                  end else if (reload_r) begin
                     tx_shift_r <= tx_data;
                     reload_r   <= 1'b0;
                  end else begin
                     tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                  end
               end
               if (cs_rise) begin
                  state_r    <= IDLE;
                  busy_r     <= 1'b0;
                  tx_shift_r <= '0;
                  bit_cnt_r  <= '0;
                  reload_r   <= 1'b0;
               end
            end
            default: begin
               state_r    <= IDLE;
               busy_r     <= 1'b0;
               tx_shift_r <= '0;
            end
         endcase
      end
   end

   assign MISO     = tx_shift_r[DATA_W-1];
   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of whole frames plus hand-written
// sequences for idle SCK activity and reset in the middle of a frame.
module tb_spi_slave;

   localparam int H = 6;

   typedef struct {
      logic        ckp;
      logic        cph;
      logic [15:0] mosi;
      int          nbits;
      logic [7:0]  tx1;
      logic [7:0]  tx2;
      logic        tog;
      int          n_rx;
      logic [7:0]  rx0;
      logic [7:0]  rx1;
      logic [15:0] miso;
      logic [7:0]  last_rx;
   } vec_t;

   logic       CLK = 1'b0;
   logic       RESET, CKP, CPH, CS, SCK, MOSI;
   logic       MISO, rx_valid, busy;
   logic [7:0] tx_data, rx_data;

   int         errors = 0;
   int         checks = 0;
   int         rx_cnt = 0;
   logic [7:0] rx_log [0:15];

   vec_t       vecs [0:3];
   vec_t       v_rst, v_after;
   logic [15:0] cap_dummy;
   int         c0;

   always #5 CLK = ~CLK;

   spi_slave #(.SYNC_STAGES(2)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .CKP      (CKP),
      .CPH      (CPH),
      .CS       (CS),
      .SCK      (SCK),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .tx_data  (tx_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy)
   );

   // Log every cycle rx_valid is high together with the byte it qualifies.
   always @(negedge CLK) begin
      if (rx_valid) begin
         if (rx_cnt < 16) rx_log[rx_cnt] <= rx_data;
         rx_cnt <= rx_cnt + 1;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Master side: opens the frame and clocks nbits, capturing MISO at its sample edges.
   task automatic xfer(input vec_t v, output logic [15:0] cap);
      cap     = 16'h0000;
      CKP     = v.ckp;
      CPH     = v.cph;
      SCK     = v.ckp;
      MOSI    = 1'b0;
      tx_data = v.tx1;
      wait_cyc(10);
      CS = 1'b0;
      if (!v.cph) MOSI = v.mosi[15];
      wait_cyc(H);
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      for (int i = 0; i < v.nbits; i++) begin
         if (i == 3) tx_data = v.tx2;
         if (i == 2 && v.tog) CKP = ~CKP;
         if (!v.cph) begin
            cap = {cap[14:0], MISO};
            SCK = ~v.ckp;
            wait_cyc(H);
            SCK = v.ckp;
            if (i < v.nbits - 1) MOSI = v.mosi[14-i];
            wait_cyc(H);
         end else begin
            SCK  = ~v.ckp;
            MOSI = v.mosi[15-i];
            wait_cyc(H);
            cap = {cap[14:0], MISO};
            SCK = v.ckp;
            wait_cyc(H);
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int          start;
      logic [15:0] cap;
      start = rx_cnt;
      xfer(v, cap);
      CS   = 1'b1;
      MOSI = 1'b0;
      wait_cyc(12);
      chk({tag, "_rx_count"}, rx_cnt - start, v.n_rx);
      if (v.n_rx >= 1) chk({tag, "_rx0"}, {24'd0, rx_log[start]}, {24'd0, v.rx0});
      if (v.n_rx >= 2) chk({tag, "_rx1"}, {24'd0, rx_log[start+1]}, {24'd0, v.rx1});
      chk({tag, "_miso_bits"}, {16'd0, cap}, {16'd0, v.miso >> (16 - v.nbits)});
      chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({tag, "_miso_idle"}, {31'd0, MISO}, 32'd0);
      chk({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, v.last_rx});
   endtask

   initial begin
      vecs[0] = '{ckp:1'b0, cph:1'b0, mosi:16'hA500, nbits:8,  tx1:8'h3C, tx2:8'h3C, tog:1'b0,
                  n_rx:1, rx0:8'hA5, rx1:8'h00, miso:16'h3C00, last_rx:8'hA5};
      vecs[1] = '{ckp:1'b1, cph:1'b1, mosi:16'h817E, nbits:16, tx1:8'h55, tx2:8'hAA, tog:1'b0,
                  n_rx:2, rx0:8'h81, rx1:8'h7E, miso:16'h55AA, last_rx:8'h7E};
      vecs[2] = '{ckp:1'b0, cph:1'b1, mosi:16'hFF00, nbits:5,  tx1:8'hF0, tx2:8'hF0, tog:1'b0,
                  n_rx:0, rx0:8'h00, rx1:8'h00, miso:16'hF000, last_rx:8'h7E};
      vecs[3] = '{ckp:1'b0, cph:1'b0, mosi:16'hC300, nbits:8,  tx1:8'h96, tx2:8'h96, tog:1'b1,
                  n_rx:1, rx0:8'hC3, rx1:8'h00, miso:16'h9600, last_rx:8'hC3};
      v_rst   = '{ckp:1'b1, cph:1'b0, mosi:16'hE000, nbits:3,  tx1:8'h77, tx2:8'h77, tog:1'b0,
                  n_rx:0, rx0:8'h00, rx1:8'h00, miso:16'h0000, last_rx:8'h00};
      v_after = '{ckp:1'b1, cph:1'b0, mosi:16'h1200, nbits:8,  tx1:8'h5A, tx2:8'h5A, tog:1'b0,
                  n_rx:1, rx0:8'h12, rx1:8'h00, miso:16'h5A00, last_rx:8'h12};

      RESET = 1'b1; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
      CKP = 1'b0; CPH = 1'b0; tx_data = 8'h00;
      wait_cyc(4);
      chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
      chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_miso", {31'd0, MISO}, 32'd0);
      RESET = 1'b0;
      wait_cyc(10);

      for (int k = 0; k < 4; k++) begin
         run_vec(vecs[k], $sformatf("vec%0d", k));
      end

      // SCK activity with CS high must be ignored.
      CKP = 1'b0; CPH = 1'b0; SCK = 1'b0;
      wait_cyc(10);
      c0 = rx_cnt;
      for (int i = 0; i < 8; i++) begin
         SCK = 1'b1; MOSI = ~MOSI;
         wait_cyc(H);
         SCK = 1'b0;
         wait_cyc(H);
      end
      wait_cyc(8);
      chk("idle_sck_rx_count", rx_cnt - c0, 32'd0);
      chk("idle_sck_busy", {31'd0, busy}, 32'd0);
      chk("idle_sck_miso", {31'd0, MISO}, 32'd0);
      chk("idle_sck_rx_data", {24'd0, rx_data}, 32'h0000_00C3);

      // Reset three bits into a mode-2 frame, CS held low across reset.
      c0 = rx_cnt;
      xfer(v_rst, cap_dummy);
      RESET = 1'b1;
      wait_cyc(2);
      RESET = 1'b0;
      wait_cyc(1);
      chk("midreset_rx_data", {24'd0, rx_data}, 32'd0);
      chk("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      chk("midreset_miso", {31'd0, MISO}, 32'd0);
      wait_cyc(20);
      chk("cs_low_after_reset_busy", {31'd0, busy}, 32'd0);
      chk("midreset_rx_count", rx_cnt - c0, 32'd0);
      CS = 1'b1;
      MOSI = 1'b0;
      run_vec(v_after, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
